// File: rtl/ddram_wr_fifo.sv
// Write-posting FIFO from the rotation stage to the DDRAM Avalon port. Same-word byte-lane writes merge into the newest queued entry.
// Latency: a write into an empty FIFO with the port idle reaches DDRAM_WE 2 cycles later (push, then load). There is no bypass.
// Backpressure: DDRAM_BUSY holds the output register. The input cannot be stalled, so a write that arrives while full is dropped and sets the sticky overflow flag.
//
// Ports:
//   clk_video, reset       sole clock; synchronous active-high reset
//   in_wr/addr/be/din      one-cycle write strobe with a 64-bit word address, byte enables and data
//   level, full, idle      queued entry count (output register excluded), full flag, quiescent flag
//   overflow, clr_overflow sticky dropped-write flag and its clear
//   DDRAM_*                single-beat Avalon write master; RD and BURSTCNT are tied off
module ddram_wr_fifo #(
    parameter int AW    = 4,
    parameter bit MERGE = 1'b1
) (
    input  logic          clk_video,
    input  logic          reset,
    input  logic          in_wr,
    input  logic [28:0]   in_addr,
    input  logic [7:0]    in_be,
    input  logic [63:0]   in_din,
    output logic [AW:0]   level,
    output logic          full,
    output logic          idle,
    output logic          overflow,
    input  logic          clr_overflow,
    output logic          DDRAM_CLK,
    input  logic          DDRAM_BUSY,
    output logic [7:0]    DDRAM_BURSTCNT,
    output logic [28:0]   DDRAM_ADDR,
    output logic [63:0]   DDRAM_DIN,
    output logic [7:0]    DDRAM_BE,
    output logic          DDRAM_WE,
    output logic          DDRAM_RD
);
    localparam int DEPTH = 1 << AW;

    logic [28:0]   addr_mem [DEPTH];
    logic [7:0]    be_mem   [DEPTH];
    logic [63:0]   din_mem  [DEPTH];

    logic [AW-1:0] wr_ptr, rd_ptr, newest;
    logic [AW:0]   level_nxt;
    logic          accept, empty, pop, merge, push, drop;
    logic [63:0]   merged_din;

    assign DDRAM_CLK      = clk_video;
    assign DDRAM_BURSTCNT = 8'd1;
    assign DDRAM_RD       = 1'b0;

    assign newest = wr_ptr - 1'b1;
    assign empty  = (level == '0);
    assign accept = DDRAM_WE & ~DDRAM_BUSY;
    assign pop    = ~empty & (~DDRAM_WE | accept);

    // A lone entry that is being popped this cycle is already on its way to
    // the output register, so it must not be merged into.
    assign merge = (MERGE != 1'b0) && in_wr && !empty && (in_addr == addr_mem[newest])
                   && ((level > (AW+1)'(1)) || !pop);

    assign push = in_wr & ~merge & ((level != (AW+1)'(DEPTH)) | pop);
    assign drop = in_wr & ~merge & ~push;

    assign idle = empty & ~DDRAM_WE;

    always_comb begin
        merged_din = din_mem[newest];
        for (int i = 0; i < 8; i++) begin
            if (in_be[i]) merged_din[8*i +: 8] = in_din[8*i +: 8];
        end
    end

    always_comb begin
        level_nxt = level;
        if (push && !pop)      level_nxt = level + 1'b1;
        else if (pop && !push) level_nxt = level - 1'b1;
    end

    // Storage is left unreset; the pointers and level define which entries are valid.
    always_ff @(posedge clk_video) begin
        if (push) begin
            addr_mem[wr_ptr] <= in_addr;
            be_mem[wr_ptr]   <= in_be;
            din_mem[wr_ptr]  <= in_din;
        end else if (merge) begin
            be_mem[newest]   <= be_mem[newest] | in_be;
            din_mem[newest]  <= merged_din;
        end
    end

    always_ff @(posedge clk_video) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            full       <= 1'b0;
            overflow   <= 1'b0;
            DDRAM_WE   <= 1'b0;
            DDRAM_ADDR <= '0;
            DDRAM_BE   <= '0;
            DDRAM_DIN  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level_nxt;
            full  <= (level_nxt == (AW+1)'(DEPTH));

            // A drop in the same cycle as a clear leaves the flag set.
            if (drop)              overflow <= 1'b1;
            else if (clr_overflow) overflow <= 1'b0;

            if (pop) begin
                DDRAM_WE   <= 1'b1;
                DDRAM_ADDR <= addr_mem[rd_ptr];
                DDRAM_BE   <= be_mem[rd_ptr];
                DDRAM_DIN  <= din_mem[rd_ptr];
            end else if (accept) begin
                DDRAM_WE   <= 1'b0;
            end
        end
    end
endmodule

// File: doc/ddram_wr_fifo.md
Name: ddram_wr_fifo

Overview:
Write-posting buffer between the rotation stage's single-word frame-buffer writes and the DDRAM Avalon port. Rotated pixels arrive one per CE_PIXEL with no backpressure, and DDRAM_BUSY stalls arbitrarily. This block absorbs the stalls in a small FIFO and merges byte-lane writes that target the same 64-bit word. It presents single-beat writes with correct Avalon hold-while-busy behaviour and flags pixel loss when the FIFO overruns.

Parameters:
AW, 4, log2 of FIFO depth; DEPTH = 2^AW entries, each holding addr + be + data.
MERGE, 1, 1 = merge an incoming write into the newest queued entry when the addresses match; 0 = never merge.

Ports:
clk_video  in  1  sole clock; also drives DDRAM_CLK.
reset  in  1  synchronous, active-high.
in_wr  in  1  one-cycle write strobe from the rotation stage.
in_addr  in  29  DDRAM 64-bit word address.
in_be  in  8  byte enables.
in_din  in  64  write data.
level  out  AW+1  number of queued FIFO entries; excludes the output register.
full  out  1  high when level == DEPTH.
idle  out  1  high when the FIFO is empty and DDRAM_WE is low.
overflow  out  1  sticky; set when a write is dropped.
clr_overflow  in  1  clears overflow.
DDRAM_CLK  out  1  = clk_video.
DDRAM_BUSY  in  1  Avalon waitrequest.
DDRAM_BURSTCNT  out  8  constant 1.
DDRAM_ADDR  out  29  registered address.
DDRAM_DIN  out  64  registered data.
DDRAM_BE  out  8  registered byte enables.
DDRAM_WE  out  1  registered write request.
DDRAM_RD  out  1  constant 0.

Behaviour:
- Reset (synchronous): DDRAM_WE=0, DDRAM_ADDR/DIN/BE=0, level=0, full=0, overflow=0, idle=1. A reset during a transfer abandons the held request and all queued entries; no recovery of lost writes.
- Output register: holds the current request. DDRAM_WE, ADDR, DIN and BE stay stable while DDRAM_WE & DDRAM_BUSY.
  - Accept = DDRAM_WE & ~DDRAM_BUSY.
  - Load (pop FIFO head into the output register) when the FIFO is non-empty and (~DDRAM_WE | accept).
  - If the FIFO is empty at accept, DDRAM_WE drops to 0 the next cycle.
- Back-to-back: with BUSY low continuously, one write is issued per cycle.
- Latency: in_wr into an empty FIFO with an idle port gives DDRAM_WE=1 exactly 2 cycles later (cycle 1 push, cycle 2 load). There is no bypass path.
- Merge (MERGE=1): an incoming write merges when all of the following hold:
  - in_addr equals the address of the newest entry;
  - level ≥ 2, or level == 1 and no pop occurs that cycle.
  - Result: per lane i, data byte = in_be[i] ? in_din byte : stored byte; be = stored_be | in_be.
  - level is unchanged.
  - The entry held in the output register is never merged into.
- Push: a non-merging in_wr is accepted when level < DEPTH, or when level == DEPTH and a pop occurs the same cycle.
  - Otherwise the write is dropped and overflow is set.
  - A merge is always accepted, even when full.
- Pointers: write and read pointers are AW bits and wrap modulo DEPTH. level is updated as +1 on push only, −1 on pop only, unchanged on push+pop or merge.
- overflow: clr_overflow clears it. If a drop and clr_overflow occur in the same cycle, set wins.
- in_wr with in_be = 0 is still queued (or merged); it is issued with BE = 0.
- full and level are registered and reflect state after the current cycle's update. idle is combinational from registered state.

Test Plan:
- Latency: reset, BUSY=0, single in_wr (addr 0x0012345, be 0x0F, din 0x11223344_55667788) -> DDRAM_WE=1 exactly 2 cycles later with identical addr/be/din for 1 cycle, then idle=1.
- Busy hold: queue 3 writes and hold BUSY=1 for 10 cycles -> ADDR/DIN/BE stable and WE=1 throughout. Release BUSY -> 3 accepts on 3 consecutive cycles, in order; level returns to 0.
- Merge:
  - Hold BUSY=1 with one entry already loaded into the output register.
  - Write addr A with be 0x0F, din low=0xAABBCCDD; then addr A with be 0xF0, din high=0x11223344.
  - Expect level=1 and a single later write: BE=0xFF, DIN=0x11223344_AABBCCDD.
  - Repeat with MERGE=0 -> level=2 and two separate writes.
- Overflow: AW=4, BUSY=1, 18 distinct-address writes -> 1 in the output register, 16 queued, full=1, 1 dropped, overflow=1. Release BUSY -> exactly 17 writes issued in order; clr_overflow clears the flag.
- Full push+pop: level=16 with in_wr coinciding with an accept -> write accepted, level stays 16, overflow stays 0.
- Reset mid-stream: BUSY=1 with 5 queued, assert reset 1 cycle -> next cycle WE=0, level=0, idle=1. Subsequent single write issues with 2-cycle latency.
